noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Per-output-port wormhole arbiter for the NoC router crossbar.
- Shares one router output link, towards a neighbour router or the local MNA, between N_PORTS input ports.
- Arbitrates round-robin on head flits and locks the grant until the packet's tail flit is accepted downstream.
- Multiplexes the granted input's flit stream onto the output with valid/ready handshake. Five instances per mesh router, one per output direction.

Parameters:
- N_PORTS, 5, number of requesting input ports (local, N, E, S, W).
- FLIT_SIZE, 34, flit width: [FLIT_SIZE-1:FLIT_SIZE-2] flit type, [FLIT_SIZE-3:0] payload.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_flit  in  N_PORTS*FLIT_SIZE  flattened input flits; port i at [i*FLIT_SIZE +: FLIT_SIZE].
- in_valid  in  N_PORTS  per-port flit valid.
- in_ready  out  N_PORTS  per-port flit accepted.
- out_flit  out  FLIT_SIZE  granted flit.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- grant  out  N_PORTS  one-hot current owner; all zero when idle.
- busy  out  1  high while a packet holds the output.
- protocol_err  out  1  one-cycle pulse on a detected framing error.

Behaviour:
- Flit types: BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11.
  - A request is in_valid[i] with type HEAD or HEAD_TAIL.
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, grant=0, busy=0, protocol_err=0.
  - in_ready=0, out_valid=0, out_flit=0.
  - A packet in flight is abandoned; upstream must be reset too.
- FSM IDLE:
  - in_ready=0, out_valid=0, out_flit=0.
  - If any request exists, pick the winner W by searching rr_ptr, rr_ptr+1, ..., N_PORTS-1, 0, ..., rr_ptr-1 (mod N_PORTS); first requester wins.
  - Registered on the clock edge: grant<=onehot(W), rr_ptr<=(W+1) mod N_PORTS, state<=LOCKED.
  - Arbitration latency is 1 cycle: the head flit appears on out_flit the cycle after it is first presented.
- FSM LOCKED, owner G:
  - Combinational: out_flit=in_flit[G], out_valid=in_valid[G], in_ready[G]=out_ready, all other in_ready=0.
  - busy=1.
  - Transfer occurs when out_valid && out_ready.
  - Transfer of TAIL or HEAD_TAIL: state<=IDLE, grant<=0.
  - Any other transfer: stay LOCKED.
- Single-cycle bubble: after a tail transfer the output is idle for exactly one cycle (IDLE arbitration) before the next head, even if requests are pending.
- in_valid[G] low while LOCKED: out_valid=0, lock is held, no timeout.
- Protocol errors: protocol_err pulses for one cycle (registered, one cycle after the condition) when either:
  - in IDLE, some in_valid[i]=1 with type BODY or TAIL (that port is ignored, not granted);
  - in LOCKED, a HEAD or HEAD_TAIL transfer occurs after the first flit of the packet.
  - The flit is still forwarded, and for HEAD_TAIL the lock is released.
- Inputs not granted see in_ready=0 and must hold their flits stable (valid/ready rule: valid is not dropped before ready).
- Wrap-around: rr_ptr after W=N_PORTS-1 is 0.

Decomposition:
- Shared package noc_pkg holds:
  - flit_type_t enum (BODY, HEAD, TAIL, HEAD_TAIL);
  - FLIT_TYPE_W=2;
  - default FLIT_SIZE;
  - port index constants LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
- One sub-module rr_arbiter: purely combinational (req[N_PORTS], ptr) -> one-hot winner plus valid.
- The FSM, pointer register and mux stay in noc_output_arbiter.

Test Plan:
- Port 2 sends HEAD/BODY/TAIL payloads 0x11000011, 0x22000022, 0x33000033 with out_ready=1:
  - out_flit shows them on 3 consecutive cycles starting 1 cycle after first in_valid;
  - grant=5'b00100 throughout; busy drops the cycle after TAIL.
- Ports 0 and 3 both present HEAD at rr_ptr=0:
  - port 0 packet completes first, then a 1-cycle gap, then port 3;
  - a repeated contention then grants port 3 before port 0 (rr_ptr=1 after port 0).
- Port 4 HEAD_TAIL single flit:
  - one transfer, returns to IDLE, rr_ptr wraps to 0.
- Backpressure: out_ready low for 4 cycles mid-packet:
  - in_ready[G]=0 and out_flit stable for those cycles, no flit lost or duplicated;
  - competing HEAD on another port not granted.
- BODY flit valid on port 1 while IDLE:
  - protocol_err pulses once, grant stays 0.
- rst asserted mid-packet (after HEAD):
  - out_valid, in_ready, grant, busy go 0 immediately (async);
  - after release a new HEAD on port 1 is granted normally with rr_ptr=0 ordering.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit encoding, widths and port indices for the NoC router
package noc_pkg;
  typedef enum logic [1:0] {BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_t;
  localparam int FLIT_TYPE_W = 2;
  localparam int FLIT_SIZE_DEF = 34;
  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST = 2;
  localparam int SOUTH = 3;
  localparam int WEST = 4;
  function automatic logic is_head(flit_type_t t);
    return t == HEAD || t == HEAD_TAIL;
  endfunction
  function automatic logic is_tail(flit_type_t t);
    return t == TAIL || t == HEAD_TAIL;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int N_PORTS = 5,
  parameter int PW = 3
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               valid
);
  // first requester at or after ptr wins; later hits are masked by valid
  always_comb begin
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!valid && req[(int'(ptr) + k) % N_PORTS]) begin
        valid = 1'b1;
        idx = PW'((int'(ptr) + k) % N_PORTS);
        gnt[(int'(ptr) + k) % N_PORTS] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: wormhole output arbiter, round-robin on heads, locked until tail
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int N_PORTS = 5,
  parameter int FLIT_SIZE = FLIT_SIZE_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS*FLIT_SIZE-1:0]   in_flit,
  input  logic [N_PORTS-1:0]             in_valid,
  output logic [N_PORTS-1:0]             in_ready,
  output logic [FLIT_SIZE-1:0]           out_flit,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_PORTS-1:0]             grant,
  output logic                           busy,
  output logic                           protocol_err
);
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state;
  logic [PW-1:0] rr_ptr, g_idx, win_idx;
  logic first;
  logic [N_PORTS-1:0] req, bad, win;
  logic win_v, locked, xfer, err_next;
  logic [FLIT_SIZE-1:0] flits [N_PORTS];
  logic [FLIT_SIZE-1:0] sel;
  flit_type_t sel_type;
  genvar i;
  for (i = 0; i < N_PORTS; i++) begin : g_port
    assign flits[i] = in_flit[i*FLIT_SIZE +: FLIT_SIZE];
    assign req[i] = in_valid[i] && is_head(flit_type_t'(flits[i][FLIT_SIZE-1 -: FLIT_TYPE_W]));
    assign bad[i] = in_valid[i] && !is_head(flit_type_t'(flits[i][FLIT_SIZE-1 -: FLIT_TYPE_W]));
  end
  rr_arbiter #(.N_PORTS(N_PORTS), .PW(PW)) u_rr (
    .req(req), .ptr(rr_ptr), .gnt(win), .idx(win_idx), .valid(win_v)
  );
  assign locked = state == LOCKED;
  assign sel = flits[g_idx];
  assign sel_type = flit_type_t'(sel[FLIT_SIZE-1 -: FLIT_TYPE_W]);
  assign out_flit = locked ? sel : '0;
  assign out_valid = locked && in_valid[g_idx];
  assign in_ready = grant & {N_PORTS{out_ready}};
  assign busy = locked;
  assign xfer = out_valid && out_ready;
  // a head after the packet's first flit, or a stray body/tail while idle, is a framing error
  assign err_next = locked ? xfer && is_head(sel_type) && !first : |bad;
  // arbitration in IDLE, lock release on tail transfer, error pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      g_idx <= '0;
      grant <= '0;
      first <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      protocol_err <= err_next;
      if (!locked && win_v) begin
        state <= LOCKED;
        grant <= win;
        g_idx <= win_idx;
        rr_ptr <= win_idx == PW'(N_PORTS - 1) ? '0 : win_idx + 1'b1;
        first <= 1'b1;
      end else if (locked && xfer) begin
        first <= 1'b0;
        if (is_tail(sel_type)) begin
          state <= IDLE;
          grant <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: directed stimulus with scoreboard-checked output stream
module tb_noc_output_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5*34-1:0] in_flit;
  logic [4:0] in_valid, in_ready, grant;
  logic [33:0] out_flit;
  logic out_valid, out_ready, busy, protocol_err;
  logic [33:0] src_f [5];
  logic src_v [5];
  typedef struct { logic [33:0] f; logic [4:0] g; } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [1:0] BD = 2'b00, HD = 2'b01, TL = 2'b10, HT = 2'b11;

  noc_output_arbiter dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_flit = '0;
    in_valid = '0;
    for (int p = 0; p < 5; p++) begin
      in_flit[p*34 +: 34] = src_f[p];
      in_valid[p] = src_v[p];
    end
  end

  function automatic logic [33:0] fl(input logic [1:0] t, input logic [31:0] pl);
    return {t, pl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [33:0] f, input logic [4:0] g);
    sb.push_back('{f, g});
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // hold each flit until the arbiter accepts it, bounded so a stuck grant cannot hang
  task automatic send(input int p, input int n, input logic [33:0] f0, input logic [33:0] f1,
                      input logic [33:0] f2, input logic [33:0] f3);
    logic [33:0] f [4];
    logic acc;
    f = '{f0, f1, f2, f3};
    for (int k = 0; k < n; k++) begin
      src_f[p] = f[k];
      src_v[p] = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready[p];
        @(posedge clk);
        #1;
      end
      chk($sformatf("accept_timeout_p%0d", p), 64'(acc), 64'd1);
    end
    src_v[p] = 1'b0;
    src_f[p] = '0;
  endtask

  // monitor: every output handshake must match the next expected flit and owner
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got flit %0h expected none", out_flit);
      end else begin
        e = sb.pop_front();
        chk("sb_flit", 64'(out_flit), 64'(e.f));
        chk("sb_grant", 64'(grant), 64'(e.g));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 5; p++) begin
      src_f[p] = '0;
      src_v[p] = 1'b0;
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_flit", 64'(out_flit), 64'd0);
    chk("rst_err", 64'(protocol_err), 64'd0);
    sync();
    rst = 1'b0;
    sync();
    // port 2 three-flit packet, one-cycle arbitration latency
    push(fl(HD, 32'h11000011), 5'b00100);
    push(fl(BD, 32'h22000022), 5'b00100);
    push(fl(TL, 32'h33000033), 5'b00100);
    fork
      send(2, 3, fl(HD, 32'h11000011), fl(BD, 32'h22000022), fl(TL, 32'h33000033), '0);
      begin
        @(negedge clk);
        chk("t1_latency_idle", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_head", 64'(out_flit), 64'(fl(HD, 32'h11000011)));
        chk("t1_grant", 64'(grant), 64'b00100);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_in_ready", 64'(in_ready), 64'b00100);
        @(negedge clk);
        chk("t1_body", 64'(out_flit), 64'(fl(BD, 32'h22000022)));
        @(negedge clk);
        chk("t1_tail", 64'(out_flit), 64'(fl(TL, 32'h33000033)));
        chk("t1_grant_tail", 64'(grant), 64'b00100);
        @(negedge clk);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        chk("t1_grant_drop", 64'(grant), 64'd0);
      end
    join
    sync();
    // port 4 single-flit packet, pointer wraps to 0
    push(fl(HT, 32'h44000044), 5'b10000);
    fork
      send(4, 1, fl(HT, 32'h44000044), '0, '0, '0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t3_grant", 64'(grant), 64'b10000);
        @(negedge clk);
        chk("t3_idle", 64'(busy), 64'd0);
        chk("t3_no_valid", 64'(out_valid), 64'd0);
      end
    join
    sync();
    // contention: port 0 wins at ptr 0, then port 3 beats port 0's second packet
    push(fl(HD, 32'h0A), 5'b00001);
    push(fl(TL, 32'h0B), 5'b00001);
    push(fl(HD, 32'h3A), 5'b01000);
    push(fl(TL, 32'h3B), 5'b01000);
    push(fl(HD, 32'h0C), 5'b00001);
    push(fl(TL, 32'h0D), 5'b00001);
    fork
      begin
        send(0, 2, fl(HD, 32'h0A), fl(TL, 32'h0B), '0, '0);
        send(0, 2, fl(HD, 32'h0C), fl(TL, 32'h0D), '0, '0);
      end
      send(3, 2, fl(HD, 32'h3A), fl(TL, 32'h3B), '0, '0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t2_first_p0", 64'(grant), 64'b00001);
        @(negedge clk);
        @(negedge clk);
        chk("t2_gap", 64'(out_valid), 64'd0);
        chk("t2_gap_grant", 64'(grant), 64'd0);
        @(negedge clk);
        chk("t2_p3_before_p0", 64'(grant), 64'b01000);
        @(negedge clk);
        @(negedge clk);
        chk("t2_gap2", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t2_p0_again", 64'(grant), 64'b00001);
      end
    join
    repeat (2) sync();
    // backpressure mid-packet with a competing head on port 2
    push(fl(HD, 32'h41), 5'b00010);
    push(fl(BD, 32'h42), 5'b00010);
    push(fl(BD, 32'h43), 5'b00010);
    push(fl(TL, 32'h44), 5'b00010);
    push(fl(HT, 32'h55), 5'b00100);
    fork
      send(1, 4, fl(HD, 32'h41), fl(BD, 32'h42), fl(BD, 32'h43), fl(TL, 32'h44));
      begin
        repeat (2) @(posedge clk);
        #1;
        send(2, 1, fl(HT, 32'h55), '0, '0, '0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk($sformatf("t4_stall_ready_%0d", c), 64'(in_ready), 64'd0);
          chk($sformatf("t4_stall_flit_%0d", c), 64'(out_flit), 64'(fl(BD, 32'h42)));
          chk($sformatf("t4_stall_grant_%0d", c), 64'(grant), 64'b00010);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (2) sync();
    // stray BODY while idle: single error pulse, no grant
    src_f[1] = fl(BD, 32'h77);
    src_v[1] = 1'b1;
    @(negedge clk);
    chk("t5_err_not_yet", 64'(protocol_err), 64'd0);
    @(posedge clk);
    #1;
    src_v[1] = 1'b0;
    src_f[1] = '0;
    @(negedge clk);
    chk("t5_err_pulse", 64'(protocol_err), 64'd1);
    chk("t5_no_grant", 64'(grant), 64'd0);
    @(negedge clk);
    chk("t5_err_once", 64'(protocol_err), 64'd0);
    chk("t5_still_idle", 64'(busy), 64'd0);
    sync();
    // async reset mid-packet, then ptr restarts at 0
    push(fl(HD, 32'h99), 5'b00001);
    src_f[0] = fl(HD, 32'h99);
    src_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_locked", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    src_v[0] = 1'b0;
    src_f[0] = '0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    sync();
    rst = 1'b0;
    sync();
    push(fl(HT, 32'hA1), 5'b00010);
    push(fl(HT, 32'hA4), 5'b10000);
    fork
      send(1, 1, fl(HT, 32'hA1), '0, '0, '0);
      send(4, 1, fl(HT, 32'hA4), '0, '0, '0);
    join
    repeat (3) sync();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
